frame_buffer_writer: RTL and testbench

FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

---
 rtl/frame_buffer_writer.sv | 170 +++++++++++++++++
 tb/tb_frame_buffer_writer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: windows a raster pixel stream into a frame buffer through one address stage and a 4-deep FWFT write FIFO.
// Optional 2x decimation is enabled by defining DECIMATE_2X_EN.
module frame_buffer_writer #(
    parameter int unsigned FRAME_WIDTH  = 512,
    parameter int unsigned FRAME_HEIGHT = 512,
    parameter int unsigned PIXEL_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH   = $clog2(FRAME_WIDTH * FRAME_HEIGHT)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   pixel_valid_in,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   sof_in,
    input  logic                   eol_in,
    input  logic [10:0]            h_offset_in,
    input  logic [9:0]             v_offset_in,
    output logic                   wr_valid_out,
    input  logic                   wr_ready_in,
    output logic [ADDR_WIDTH-1:0]  wr_addr_out,
    output logic [PIXEL_WIDTH-1:0] wr_data_out,
    output logic                   frame_done_out,
    output logic                   overflow_out,
    output logic                   busy_out
);
    localparam int unsigned H_W        = 11;
    localparam int unsigned V_W        = 10;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
`ifdef DECIMATE_2X_EN
    localparam int unsigned WIN_W = 2 * FRAME_WIDTH;
    localparam int unsigned WIN_H = 2 * FRAME_HEIGHT;
`else
    localparam int unsigned WIN_W = FRAME_WIDTH;
    localparam int unsigned WIN_H = FRAME_HEIGHT;
`endif

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [H_W-1:0]         h_cnt, h_off, px, hof;
    logic [V_W-1:0]         v_cnt, v_off, py, vof;
    logic [31:0]            dx, dy;
    logic                   accept, in_win, last_line, done_nxt;
    logic [ADDR_WIDTH-1:0]  pix_addr;

    logic                   st_valid;
    logic [ADDR_WIDTH-1:0]  st_addr;
    logic [PIXEL_WIDTH-1:0] st_data;

    logic [ADDR_WIDTH-1:0]  fifo_addr [FIFO_DEPTH];
    logic [PIXEL_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr, wr_ptr, rd_nxt;
    logic [CNT_W-1:0]       fifo_cnt, cnt_nxt;
    logic                   pop, push_ok, ovf_set;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [PIXEL_WIDTH-1:0] head_data;

    // Source coordinate of the current pixel; an SOF pixel is (0,0) and uses the live offsets
    always_comb begin
        px = h_cnt;
        py = v_cnt;
        hof = h_off;
        vof = v_off;
        if (sof_in) begin
            px  = '0;
            py  = '0;
            hof = h_offset_in;
            vof = v_offset_in;
        end
        accept = pixel_valid_in && (sof_in || state == ACTIVE);
        dx = 32'(px) - 32'(hof);
        dy = 32'(py) - 32'(vof);
        in_win = (px >= hof) && (dx < WIN_W) && (py >= vof) && (dy < WIN_H);
`ifdef DECIMATE_2X_EN
        in_win   = in_win && !px[0] && !py[0];
        pix_addr = ADDR_WIDTH'((dy >> 1) * FRAME_WIDTH + (dx >> 1));
`else
        pix_addr = ADDR_WIDTH'(dy * FRAME_WIDTH + dx);
`endif
        last_line = eol_in && (32'(py) == 32'(vof) + WIN_H - 32'd1);
    end

    // Frame sequencing: SOF always (re)starts a frame, DRAIN completes once the write path is empty
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (accept) begin
            state_nxt = last_line ? DRAIN : ACTIVE;
        end else if (state == DRAIN && !st_valid && fifo_cnt == '0) begin
            state_nxt = WAIT_SOF;
            done_nxt  = 1'b1;
        end
    end

    // FIFO bookkeeping; the head for the next cycle is precomputed so the write port is registered
    always_comb begin
        pop     = (fifo_cnt != '0) && wr_ready_in;
        push_ok = st_valid && ((fifo_cnt < CNT_W'(FIFO_DEPTH)) || pop);
        ovf_set = st_valid && !push_ok;
        cnt_nxt = fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);
        rd_nxt  = rd_ptr + PTR_W'(pop);
        head_addr = fifo_addr[rd_nxt];
        head_data = fifo_data[rd_nxt];
        if (push_ok && rd_nxt == wr_ptr) begin
            head_addr = st_addr;
            head_data = st_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= st_addr;
            fifo_data[wr_ptr] <= st_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= WAIT_SOF;
            h_cnt          <= '0;
            v_cnt          <= '0;
            h_off          <= '0;
            v_off          <= '0;
            st_valid       <= 1'b0;
            st_addr        <= '0;
            st_data        <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_cnt       <= '0;
            wr_valid_out   <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            frame_done_out <= 1'b0;
            overflow_out   <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (eol_in) begin
                    h_cnt <= '0;
                    v_cnt <= (&py) ? py : py + 1'b1;
                end else begin
                    h_cnt <= (&px) ? px : px + 1'b1;
                    v_cnt <= py;
                end
            end
            if (pixel_valid_in && sof_in) begin
                h_off <= h_offset_in;
                v_off <= v_offset_in;
            end
            st_valid <= accept && in_win;
            if (accept && in_win) begin
                st_addr <= pix_addr;
                st_data <= pixel_in;
            end
            rd_ptr   <= rd_nxt;
            wr_ptr   <= wr_ptr + PTR_W'(push_ok);
            fifo_cnt <= cnt_nxt;
            wr_valid_out <= (cnt_nxt != '0);
            if (cnt_nxt != '0) begin
                wr_addr_out <= head_addr;
                wr_data_out <= head_data;
            end
            frame_done_out <= done_nxt;
            overflow_out   <= overflow_out | ovf_set;
            busy_out       <= (state_nxt != WAIT_SOF);
        end
    end
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: randomized stimulus checked cycle by cycle against a queue-based model of the frame writer.
`timescale 1ns/1ps
module tb_frame_buffer_writer;
    localparam int unsigned FW = 16;
    localparam int unsigned FH = 8;
    localparam int unsigned PW = 16;
    localparam int unsigned AW = 7;
`ifdef DECIMATE_2X_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int WIN_W = FW * S;
    localparam int WIN_H = FH * S;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          pixel_valid_in;
    logic [PW-1:0] pixel_in;
    logic          sof_in;
    logic          eol_in;
    logic [10:0]   h_offset_in;
    logic [9:0]    v_offset_in;
    logic          wr_valid_out;
    logic          wr_ready_in;
    logic [AW-1:0] wr_addr_out;
    logic [PW-1:0] wr_data_out;
    logic          frame_done_out;
    logic          overflow_out;
    logic          busy_out;

    always #5 clk_in = ~clk_in;

    frame_buffer_writer #(
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .pixel_valid_in(pixel_valid_in), .pixel_in(pixel_in),
        .sof_in(sof_in), .eol_in(eol_in),
        .h_offset_in(h_offset_in), .v_offset_in(v_offset_in),
        .wr_valid_out(wr_valid_out), .wr_ready_in(wr_ready_in),
        .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
        .frame_done_out(frame_done_out), .overflow_out(overflow_out), .busy_out(busy_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: source position, frame status, one delay slot and a bounded write queue
    int          m_x, m_y, m_ho, m_vo;
    bit          m_in_frame, m_pend, m_done, m_ovf;
    bit          m_st_v;
    int          m_st_a;
    logic [PW-1:0] m_st_d;
    int          q_a[$];
    logic [PW-1:0] q_d[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_ho = 0; m_vo = 0;
        m_in_frame = 0; m_pend = 0; m_done = 0; m_ovf = 0; m_st_v = 0;
        q_a.delete(); q_d.delete();
    endtask

    task automatic model_edge();
        bit nst_v = 0;
        bit elig;
        m_done = m_pend && !m_st_v && q_a.size() == 0 && !(pixel_valid_in && sof_in);
        if (m_done) m_pend = 0;
        if (q_a.size() != 0 && wr_ready_in) begin
            void'(q_a.pop_front());
            void'(q_d.pop_front());
        end
        if (m_st_v) begin
            if (q_a.size() < 4) begin
                q_a.push_back(m_st_a);
                q_d.push_back(m_st_d);
            end else begin
                m_ovf = 1;
            end
        end
        if (pixel_valid_in && sof_in) begin
            m_ho = int'(h_offset_in); m_vo = int'(v_offset_in);
            m_x = 0; m_y = 0; m_in_frame = 1; m_pend = 0;
        end
        if (pixel_valid_in && m_in_frame) begin
            elig = (S == 1) || (m_x % 2 == 0 && m_y % 2 == 0);
            if (elig && m_x >= m_ho && m_x - m_ho < WIN_W && m_y >= m_vo && m_y - m_vo < WIN_H) begin
                nst_v  = 1;
                m_st_a = ((m_y - m_vo) / S) * FW + (m_x - m_ho) / S;
                m_st_d = pixel_in;
            end
            if (eol_in && m_y == m_vo + WIN_H - 1) begin
                m_in_frame = 0; m_pend = 1;
            end
            if (eol_in) begin
                m_x = 0;
                m_y = (m_y < 1023) ? m_y + 1 : 1023;
            end else begin
                m_x = (m_x < 2047) ? m_x + 1 : 2047;
            end
        end
        m_st_v = nst_v;
    endtask

    task automatic compare_outputs();
        check("wr_valid", wr_valid_out, q_a.size() != 0);
        if (q_a.size() != 0) begin
            check("wr_addr", wr_addr_out, q_a[0]);
            check("wr_data", wr_data_out, q_d[0]);
        end
        check("frame_done", frame_done_out, m_done);
        check("overflow", overflow_out, m_ovf);
        check("busy", busy_out, m_in_frame || m_pend);
    endtask

    task automatic step(input bit v, input bit s, input bit e, input bit [10:0] ho, input bit [9:0] vo, input bit rdy);
        pixel_valid_in = v; sof_in = s; eol_in = e;
        pixel_in = PW'($urandom);
        h_offset_in = ho; v_offset_in = vo; wr_ready_in = rdy;
        @(posedge clk_in);
        model_edge();
        #1;
        compare_outputs();
    endtask

    function automatic bit rdy(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic idle(input int pct);
        step(0, 1'($urandom), 1'($urandom), 11'($urandom), 10'($urandom), rdy(pct));
    endtask

    // Raster source of sw x sh pixels; offsets are only meaningful on the SOF pixel
    task automatic send_frame(input int sw, input int sh, input int ho, input int vo, input int gap_pct, input int rdy_pct);
        for (int y = 0; y < sh; y++) begin
            for (int x = 0; x < sw; x++) begin
                while ($urandom_range(99) < gap_pct) idle(rdy_pct);
                if (x == 0 && y == 0)
                    step(1, 1, sw == 1, 11'(ho), 10'(vo), rdy(rdy_pct));
                else
                    step(1, 0, x == sw - 1, 11'($urandom), 10'($urandom), rdy(rdy_pct));
            end
        end
    endtask

    task automatic drain_idle(input int budget);
        int n = 0;
        while ((q_a.size() != 0 || m_st_v || m_pend) && n < budget) begin
            step(0, 0, 0, 0, 0, 1);
            n++;
        end
        check("drain_budget", n < budget, 1);
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_valid"}, wr_valid_out, 0);
        check({tag, "_wr_addr"}, wr_addr_out, 0);
        check({tag, "_wr_data"}, wr_data_out, 0);
        check({tag, "_frame_done"}, frame_done_out, 0);
        check({tag, "_overflow"}, overflow_out, 0);
        check({tag, "_busy"}, busy_out, 0);
    endtask

    initial begin
        rst_n_in = 1'b0;
        pixel_valid_in = 0; pixel_in = '0; sof_in = 0; eol_in = 0;
        h_offset_in = '0; v_offset_in = '0; wr_ready_in = 1'b1;
        model_reset();
        #12;
        check_reset_outputs("por");
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Non-SOF pixels before any frame are discarded
        for (int i = 0; i < 6; i++) step(1, 0, 1'($urandom), 0, 0, 1);

        // Exact-fit frame, no offsets, always ready: first write two cycles after SOF
        step(1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check("first_write_latency", wr_valid_out, 1);
        check("first_write_addr", wr_addr_out, 0);
        drain_idle(50);
        send_frame(WIN_W, WIN_H, 0, 0, 0, 100);
        drain_idle(50);

        // Fixed offsets with margin, then randomized offsets, gaps and back-pressure
        send_frame(WIN_W + 12, WIN_H + 7, 10, 5, 0, 100);
        drain_idle(50);
        for (int k = 0; k < 3; k++) begin
            send_frame(WIN_W + 3 + k, WIN_H + 2, $urandom_range(0, 6), $urandom_range(0, 4), 20, 70);
            drain_idle(100);
        end

        // Frame restarted part-way through, then a new SOF arriving while the previous frame drains
        send_frame(WIN_W + 4, 3, 2, 1, 10, 50);
        send_frame(WIN_W, WIN_H, 0, 0, 0, 30);
        send_frame(WIN_W, WIN_H, 1, 1, 0, 80);
        drain_idle(100);

        // Horizontal counter saturation: a very long line must never re-enter the window
        send_frame(2060, 2, 0, 0, 0, 100);
        // Vertical counter saturation near the bottom of the offset range
        send_frame(1, 1030, 0, 1020, 0, 100);
        drain_idle(50);

        // Back-pressure with continuous pixels overflows the FIFO
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 11'($urandom), 10'($urandom), 0);
        check("overflow_set", overflow_out, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 1);
        drain_idle(50);

        // Asynchronous reset with queued entries
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("pre_reset_valid", wr_valid_out, 1);
        #1 rst_n_in = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        #1 rst_n_in = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 0, 1'($urandom), 0, 0, 1);

        // Recovery frame after reset
        send_frame(WIN_W + 2, WIN_H + 1, 1, 0, 15, 60);
        drain_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation time limit reached, expected finish");
        $fatal(1);
    end
endmodule
